// File: rtl/riscv_apu_disp_pkg.sv
// rtl/riscv_apu_disp_pkg.sv - shared latency-class constants and helpers for the APU dispatcher
package riscv_apu_disp_pkg;

    localparam logic [1:0] LAT_PIPE  = 2'd0;
    localparam logic [1:0] LAT_1     = 2'd1;
    localparam logic [1:0] LAT_2     = 2'd2;
    localparam logic [1:0] LAT_MULTI = 2'd3;

    // An op of this class cannot be issued behind in-flight work: single-cycle
    // and multicycle results would collide with pending writebacks, and a
    // two-cycle op may overtake a multicycle op issued just before it.
    function automatic logic lat_blocks(input logic [1:0] lat, input logic [1:0] last_lat);
        return (lat == LAT_1) || (lat == LAT_MULTI) ||
               ((lat == LAT_2) && (last_lat == LAT_MULTI));
    endfunction

endpackage

// File: rtl/riscv_apu_disp_tracker.sv
// rtl/riscv_apu_disp_tracker.sv - in-order destination FIFO with parallel register-hazard compare
module riscv_apu_disp_tracker #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 6,
    parameter int N_RD   = 3,
    parameter int N_WR   = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic [ADDR_W-1:0]            push_addr_i,
    input  logic                         pop_i,
    output logic [ADDR_W-1:0]            head_addr_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    input  logic [N_RD*ADDR_W-1:0]       read_regs_i,
    input  logic [N_WR*ADDR_W-1:0]       write_regs_i,
    output logic [N_RD-1:0]              read_hit_o,
    output logic [N_WR-1:0]              write_hit_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [PW-1:0]     wptr_q;
    logic [PW-1:0]     rptr_q;
    logic [CW-1:0]     count_q;
    logic [DEPTH-1:0]  live;

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            vld_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop_i) begin
                vld_q[rptr_q] <= 1'b0;
                rptr_q        <= rptr_q + 1'b1;
            end
            if (push_i) begin
                mem_q[wptr_q] <= push_addr_i;
                vld_q[wptr_q] <= 1'b1;
                wptr_q        <= wptr_q + 1'b1;
            end
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Entries still pending after this cycle: a head being popped no longer blocks decode.
    always_comb begin
        live = vld_q;
        if (pop_i) live[rptr_q] = 1'b0;
    end

    // Compare every operand port against every live entry in parallel.
    always_comb begin
        read_hit_o  = '0;
        write_hit_o = '0;
        for (int p = 0; p < N_RD; p++)
            for (int e = 0; e < DEPTH; e++)
                if (live[e] && (mem_q[e] == read_regs_i[p*ADDR_W +: ADDR_W]))
                    read_hit_o[p] = 1'b1;
        for (int p = 0; p < N_WR; p++)
            for (int e = 0; e < DEPTH; e++)
                if (live[e] && (mem_q[e] == write_regs_i[p*ADDR_W +: ADDR_W]))
                    write_hit_o[p] = 1'b1;
    end

    assign head_addr_o = mem_q[rptr_q];
    assign count_o     = count_q;

endmodule

// File: rtl/riscv_apu_disp_fifo.sv
// rtl/riscv_apu_disp_fifo.sv - APU dispatcher: issue control, stall causes, hazard and response tracking
module riscv_apu_disp_fifo
    import riscv_apu_disp_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 6,
    parameter int N_RD   = 3,
    parameter int N_WR   = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         enable_i,
    input  logic [1:0]                   apu_lat_i,
    input  logic [ADDR_W-1:0]            apu_waddr_i,
    output logic [ADDR_W-1:0]            apu_waddr_o,
    output logic                         apu_multicycle_o,
    output logic                         apu_singlecycle_o,
    output logic                         active_o,
    output logic                         stall_o,
    input  logic                         is_decoding_i,
    input  logic [N_RD*ADDR_W-1:0]       read_regs_i,
    input  logic [N_RD-1:0]              read_regs_valid_i,
    output logic                         read_dep_o,
    input  logic [N_WR*ADDR_W-1:0]       write_regs_i,
    input  logic [N_WR-1:0]              write_regs_valid_i,
    output logic                         write_dep_o,
    output logic                         perf_type_o,
    output logic                         perf_cont_o,
    output logic                         apu_master_req_o,
    output logic                         apu_master_ready_o,
    input  logic                         apu_master_gnt_i,
    input  logic                         apu_master_valid_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         err_o
);

    localparam int CW = $clog2(DEPTH+1);

    logic [1:0]        last_lat_q;
    logic              err_q;
    logic [CW-1:0]     count;
    logic [ADDR_W-1:0] head_addr;
    logic [N_RD-1:0]   read_hit;
    logic [N_WR-1:0]   write_hit;
    logic [N_RD-1:0]   read_new;
    logic [N_WR-1:0]   write_new;

    logic active, empty, stall_full, stall_type, stall_nack;
    logic valid_req, accept, same_ret, push, pop, stray;

    assign active     = (count != '0);
    assign empty      = !active;
    assign stall_full = (count == CW'(DEPTH));
    assign stall_type = enable_i && active && lat_blocks(apu_lat_i, last_lat_q);
    assign valid_req  = enable_i && !(stall_full || stall_type);
    assign accept     = valid_req && apu_master_gnt_i;
    assign stall_nack = valid_req && !apu_master_gnt_i;
    // A result arriving with nothing outstanding belongs to the op granted this cycle.
    assign same_ret   = accept && apu_master_valid_i && empty;
    assign pop        = apu_master_valid_i && !empty;
    assign push       = accept && !same_ret;
    assign stray      = apu_master_valid_i && empty && !accept;

    riscv_apu_disp_tracker #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .N_RD   (N_RD),
        .N_WR   (N_WR)
    ) u_tracker (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (push),
        .push_addr_i  (apu_waddr_i),
        .pop_i        (pop),
        .head_addr_o  (head_addr),
        .count_o      (count),
        .read_regs_i  (read_regs_i),
        .write_regs_i (write_regs_i),
        .read_hit_o   (read_hit),
        .write_hit_o  (write_hit)
    );

    // Latency class of the last requested op and the sticky stray-response flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_lat_q <= LAT_PIPE;
            err_q      <= 1'b0;
        end else begin
            if (valid_req) last_lat_q <= apu_lat_i;
            if (stray)     err_q      <= 1'b1;
        end
    end

    // The op being requested now counts as a hazard unless it retires this same cycle.
    always_comb begin
        read_new  = '0;
        write_new = '0;
        for (int p = 0; p < N_RD; p++)
            read_new[p] = valid_req && !same_ret &&
                          (read_regs_i[p*ADDR_W +: ADDR_W] == apu_waddr_i);
        for (int p = 0; p < N_WR; p++)
            write_new[p] = valid_req && !same_ret &&
                           (write_regs_i[p*ADDR_W +: ADDR_W] == apu_waddr_i);
    end

    // Writeback address: the bypassed op, else the head being retired, else idle.
    always_comb begin
        apu_waddr_o = '0;
        if (same_ret)  apu_waddr_o = apu_waddr_i;
        else if (pop)  apu_waddr_o = head_addr;
    end

    assign read_dep_o         = is_decoding_i && |(read_regs_valid_i & (read_hit | read_new));
    assign write_dep_o        = is_decoding_i && |(write_regs_valid_i & (write_hit | write_new));
    assign stall_o            = stall_full || stall_type || stall_nack;
    assign perf_type_o        = stall_type;
    assign perf_cont_o        = stall_nack;
    assign apu_master_req_o   = valid_req;
    assign apu_master_ready_o = 1'b1;
    assign active_o           = active;
    assign apu_singlecycle_o  = empty;
    assign apu_multicycle_o   = (last_lat_q == LAT_MULTI) || ((last_lat_q == LAT_PIPE) && active);
    assign count_o            = count;
    assign err_o              = err_q;

endmodule

// File: tb/tb_riscv_apu_disp_fifo.sv
// tb/tb_riscv_apu_disp_fifo.sv - self-checking bench for riscv_apu_disp_fifo
module tb_riscv_apu_disp_fifo;

    localparam int DEPTH = 4;
    localparam int AW    = 6;
    localparam int NR    = 3;
    localparam int NW    = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          enable_i;
    logic [1:0]    apu_lat_i;
    logic [AW-1:0] apu_waddr_i;
    logic [AW-1:0] apu_waddr_o;
    logic          apu_multicycle_o, apu_singlecycle_o, active_o, stall_o;
    logic          is_decoding_i;
    logic [NR*AW-1:0] read_regs_i;
    logic [NR-1:0] read_regs_valid_i;
    logic          read_dep_o;
    logic [NW*AW-1:0] write_regs_i;
    logic [NW-1:0] write_regs_valid_i;
    logic          write_dep_o;
    logic          perf_type_o, perf_cont_o;
    logic          apu_master_req_o, apu_master_ready_o, apu_master_gnt_i, apu_master_valid_i;
    logic [2:0]    count_o;
    logic          err_o;

    riscv_apu_disp_fifo #(.DEPTH(DEPTH), .ADDR_W(AW), .N_RD(NR), .N_WR(NW)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .enable_i           (enable_i),
        .apu_lat_i          (apu_lat_i),
        .apu_waddr_i        (apu_waddr_i),
        .apu_waddr_o        (apu_waddr_o),
        .apu_multicycle_o   (apu_multicycle_o),
        .apu_singlecycle_o  (apu_singlecycle_o),
        .active_o           (active_o),
        .stall_o            (stall_o),
        .is_decoding_i      (is_decoding_i),
        .read_regs_i        (read_regs_i),
        .read_regs_valid_i  (read_regs_valid_i),
        .read_dep_o         (read_dep_o),
        .write_regs_i       (write_regs_i),
        .write_regs_valid_i (write_regs_valid_i),
        .write_dep_o        (write_dep_o),
        .perf_type_o        (perf_type_o),
        .perf_cont_o        (perf_cont_o),
        .apu_master_req_o   (apu_master_req_o),
        .apu_master_ready_o (apu_master_ready_o),
        .apu_master_gnt_i   (apu_master_gnt_i),
        .apu_master_valid_i (apu_master_valid_i),
        .count_o            (count_o),
        .err_o              (err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model state: outstanding destinations in issue order.
    int q[$];
    int m_last_lat = 0;
    int m_err = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        enable_i = 0; apu_lat_i = 0; apu_waddr_i = 0;
        apu_master_gnt_i = 0; apu_master_valid_i = 0;
        is_decoding_i = 0; read_regs_i = '0; read_regs_valid_i = '0;
        write_regs_i = '0; write_regs_valid_i = '0;
    endtask

    function automatic int in_flight_match(input int a, input int skip_head);
        for (int k = skip_head; k < q.size(); k++)
            if (q[k] == a) return 1;
        return 0;
    endfunction

    // Inputs are already driven (just after a rising edge); check mid-cycle, then advance the model.
    task automatic step();
        int cnt, sf, st, vreq, acc, same, pop, nack, exp_wa, rd, wd, ra, lat, wa;
        #3;
        cnt  = q.size();
        lat  = int'(apu_lat_i);
        wa   = int'(apu_waddr_i);
        sf   = (cnt == DEPTH);
        st   = enable_i && cnt > 0 &&
               (lat == 1 || lat == 3 || (lat == 2 && m_last_lat == 3));
        vreq = enable_i && !sf && !st;
        acc  = vreq && apu_master_gnt_i;
        nack = vreq && !apu_master_gnt_i;
        same = acc && apu_master_valid_i && cnt == 0;
        pop  = apu_master_valid_i && cnt > 0;
        exp_wa = same ? wa : (pop ? q[0] : 0);
        rd = 0;
        for (int p = 0; p < NR; p++) begin
            ra = int'(read_regs_i[p*AW +: AW]);
            if (read_regs_valid_i[p] &&
                ((vreq && !same && ra == wa) || in_flight_match(ra, pop)))
                rd = 1;
        end
        wd = 0;
        for (int p = 0; p < NW; p++) begin
            ra = int'(write_regs_i[p*AW +: AW]);
            if (write_regs_valid_i[p] &&
                ((vreq && !same && ra == wa) || in_flight_match(ra, pop)))
                wd = 1;
        end
        check("req",        int'(apu_master_req_o),  vreq);
        check("stall",      int'(stall_o),           (sf || st || nack) ? 1 : 0);
        check("perf_type",  int'(perf_type_o),       st);
        check("perf_cont",  int'(perf_cont_o),       nack);
        check("waddr_o",    int'(apu_waddr_o),       exp_wa);
        check("count",      int'(count_o),           cnt);
        check("active",     int'(active_o),          cnt > 0 ? 1 : 0);
        check("single",     int'(apu_singlecycle_o), cnt == 0 ? 1 : 0);
        check("multi",      int'(apu_multicycle_o),
              (m_last_lat == 3 || (m_last_lat == 0 && cnt > 0)) ? 1 : 0);
        check("read_dep",   int'(read_dep_o),        (is_decoding_i && rd) ? 1 : 0);
        check("write_dep",  int'(write_dep_o),       (is_decoding_i && wd) ? 1 : 0);
        check("err",        int'(err_o),             m_err);
        check("ready",      int'(apu_master_ready_o), 1);
        @(posedge clk_i);
        if (apu_master_valid_i && cnt == 0 && !acc) m_err = 1;
        if (pop) void'(q.pop_front());
        if (acc && !same) q.push_back(wa);
        if (vreq) m_last_lat = lat;
        #1;
    endtask

    task automatic issue(input int lat, input int wa, input int gnt, input int val);
        idle();
        enable_i = 1; apu_lat_i = 2'(lat); apu_waddr_i = AW'(wa);
        apu_master_gnt_i = gnt[0]; apu_master_valid_i = val[0];
        step();
    endtask

    task automatic respond();
        idle();
        apu_master_valid_i = 1;
        step();
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 0;
        q.delete(); m_last_lat = 0; m_err = 0;
        @(negedge clk_i);
        rst_ni = 1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        idle();
        rst_ni = 0;
        #12;
        check("rst_count",  int'(count_o), 0);
        check("rst_single", int'(apu_singlecycle_o), 1);
        check("rst_ready",  int'(apu_master_ready_o), 1);
        check("rst_req",    int'(apu_master_req_o), 0);
        check("rst_err",    int'(err_o), 0);
        check("rst_multi",  int'(apu_multicycle_o), 0);
        do_reset();

        // Fill to DEPTH with pipelined ops, then a fifth op must stall.
        for (int i = 1; i <= DEPTH; i++) issue(0, i, 1, 0);
        check("full_count", int'(count_o), DEPTH);
        enable_i = 1; apu_lat_i = 0; apu_waddr_i = 6'd9; apu_master_gnt_i = 1;
        #2;
        check("full_stall", int'(stall_o), 1);
        check("full_req",   int'(apu_master_req_o), 0);
        step();
        // Full with a pop: still stalled this cycle.
        idle(); enable_i = 1; apu_waddr_i = 6'd10; apu_master_gnt_i = 1; apu_master_valid_i = 1;
        step();
        for (int i = 0; i < DEPTH - 1; i++) respond();

        // Same-cycle return on an empty FIFO.
        issue(0, 5, 1, 1);
        check("bypass_count", int'(count_o), 0);

        // In-order return with a concurrent push.
        issue(0, 3, 1, 0);
        issue(0, 7, 1, 0);
        issue(0, 9, 1, 1);
        check("pushpop_count", int'(count_o), 2);
        respond();
        respond();

        // Read dependency on an in-flight destination, cleared when it pops.
        issue(0, 7, 1, 0);
        idle(); is_decoding_i = 1; read_regs_i[1*AW +: AW] = 6'd7; read_regs_valid_i = 3'b010;
        step();
        idle(); is_decoding_i = 1; read_regs_i[1*AW +: AW] = 6'd7; read_regs_valid_i = 3'b010;
        apu_master_valid_i = 1;
        step();

        // Latency-class stall and grant-refused stall.
        issue(3, 2, 1, 0);
        issue(2, 4, 1, 0);
        respond();
        issue(0, 6, 0, 0);

        // Stray response, sticky error, asynchronous reset mid-operation.
        respond();
        idle(); step();
        check("err_sticky", int'(err_o), 1);
        issue(0, 11, 1, 0);
        issue(0, 12, 1, 0);
        #2;
        rst_ni = 0;
        #1;
        check("async_count", int'(count_o), 0);
        check("async_err",   int'(err_o), 0);
        do_reset();
        respond();
        check("post_rst_err", int'(err_o), 1);
        do_reset();

        // Randomized traffic against the queue model.
        for (int n = 0; n < 400; n++) begin
            idle();
            enable_i           = 1'($urandom_range(0, 3) != 0);
            apu_lat_i          = 2'($urandom_range(0, 3));
            apu_waddr_i        = AW'($urandom_range(0, 7));
            apu_master_gnt_i   = 1'($urandom_range(0, 3) != 0);
            apu_master_valid_i = (q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 15) == 0 && enable_i);
            is_decoding_i      = 1'($urandom_range(0, 1));
            for (int p = 0; p < NR; p++) read_regs_i[p*AW +: AW] = AW'($urandom_range(0, 7));
            for (int p = 0; p < NW; p++) write_regs_i[p*AW +: AW] = AW'($urandom_range(0, 7));
            read_regs_valid_i  = NR'($urandom);
            write_regs_valid_i = NW'($urandom);
            step();
            if (m_err != 0 && $urandom_range(0, 3) == 0) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
